// File: rtl/uart_rx_bcd_parser.sv
// -----------------------------------------------------------------------------
// uart_rx_bcd_parser
//
// Purpose:
//   8N1 UART receiver feeding a line parser. The parser collects up to eight
//   ASCII decimal digits into a packed-BCD number. A CR or LF ends the line.
//   A well-formed line is published on value/ndigits with value_strobe.
//   A malformed line is rejected with parse_err when its terminator arrives.
//   Malformed means: a non-digit character, more than eight digits, or a
//   framing error.
//
// Ports:
//   clk          in   system clock; all state changes on its rising edge
//   reset_n      in   asynchronous active-low reset
//   serial_rx    in   asynchronous UART line, 8N1, idles high
//   rx_data      out  [7:0]  last correctly framed byte
//   rx_strobe    out  one-cycle pulse; rx_data is updated in this cycle
//   frame_err    out  one-cycle pulse; the stop bit was sampled low
//   value        out  [31:0] last accepted number, 8 packed BCD digits,
//                     least significant digit in [3:0]
//   ndigits      out  [3:0]  digit count of value (1..8)
//   value_strobe out  one-cycle pulse; value/ndigits are updated in this cycle
//   parse_err    out  one-cycle pulse; a malformed line was rejected
//
// Parameters:
//   CLKS_PER_BIT clk cycles per UART bit (104 = 12 MHz / 115200 baud)
// -----------------------------------------------------------------------------
module uart_rx_bcd_parser #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        serial_rx,
  output logic [7:0]  rx_data,
  output logic        rx_strobe,
  output logic        frame_err,
  output logic [31:0] value,
  output logic [3:0]  ndigits,
  output logic        value_strobe,
  output logic        parse_err
);

  // The counter only ever needs to reach CLKS_PER_BIT-1.
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic {
    P_ACC,
    P_DISCARD
  } p_state_t;

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  logic [1:0]       sync_q;
  rx_state_t        rx_state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_strobe_q;
  logic             frame_err_q;
  logic             line;

  // Only the second synchronizer flop is used, so metastability never reaches
  // the FSM.
  assign line = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 2'b11;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], serial_rx};
      rx_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;

      case (rx_state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (!line) begin
            rx_state_q <= RX_START;
          end
        end

        // Check the line again at mid-start-bit. A line that is already high
        // again was only a glitch. This check also aligns every later sample
        // with the centre of its bit.
        RX_START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            if (line) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // LSB arrives first, so shift in from the top.
        RX_DATA: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q   <= '0;
            shift_q <= {line, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        RX_STOP: begin
          if (cnt_q == FULL_CNT) begin
            cnt_q <= '0;
            if (line) begin
              rx_data_q   <= shift_q;
              rx_strobe_q <= 1'b1;
              rx_state_q  <= RX_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              rx_state_q  <= RX_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // A break (line held low) must not be read as a run of zero bytes.
        RX_WAIT_HIGH: begin
          cnt_q <= '0;
          if (line) begin
            rx_state_q <= RX_IDLE;
          end
        end

        default: begin
          rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_strobe = rx_strobe_q;
  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------------------
  // Parser: consumes the registered receiver pulses, adds one cycle of latency
  // ---------------------------------------------------------------------------
  p_state_t    p_state_q;
  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [3:0]  dcnt_q;
  logic [31:0] value_q;
  logic [3:0]  ndigits_q;
  logic        value_strobe_q;
  logic        parse_err_q;
  logic        is_digit;
  logic        is_term;

  // rx_data_q already holds the new byte in the rx_strobe cycle.
  assign is_digit = (rx_data_q >= ASCII_0) && (rx_data_q <= ASCII_9);
  assign is_term  = (rx_data_q == ASCII_CR) || (rx_data_q == ASCII_LF);
  assign acc_d    = {acc_q[27:0], rx_data_q[3:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_state_q      <= P_ACC;
      acc_q          <= '0;
      dcnt_q         <= '0;
      value_q        <= '0;
      ndigits_q      <= '0;
      value_strobe_q <= 1'b0;
      parse_err_q    <= 1'b0;
    end else begin
      value_strobe_q <= 1'b0;
      parse_err_q    <= 1'b0;

      if (frame_err_q) begin
        // A corrupted byte poisons the whole line.
        p_state_q <= P_DISCARD;
      end else if (rx_strobe_q) begin
        case (p_state_q)
          P_ACC: begin
            if (is_digit) begin
              if (dcnt_q < 4'd8) begin
                acc_q  <= acc_d;
                dcnt_q <= dcnt_q + 1'b1;
              end else begin
                p_state_q <= P_DISCARD;
              end
            end else if (is_term) begin
              // An empty line (e.g. the LF of a CR LF pair) is ignored.
              if (dcnt_q != 4'd0) begin
                value_q        <= acc_q;
                ndigits_q      <= dcnt_q;
                value_strobe_q <= 1'b1;
                acc_q          <= '0;
                dcnt_q         <= '0;
              end
            end else begin
              p_state_q <= P_DISCARD;
            end
          end

          P_DISCARD: begin
            if (is_term) begin
              parse_err_q <= 1'b1;
              acc_q       <= '0;
              dcnt_q      <= '0;
              p_state_q   <= P_ACC;
            end
          end

          default: begin
            p_state_q <= P_ACC;
          end
        endcase
      end
    end
  end

  assign value        = value_q;
  assign ndigits      = ndigits_q;
  assign value_strobe = value_strobe_q;
  assign parse_err    = parse_err_q;

endmodule
